alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 19 +
 rtl/alu_ctrl.sv | 99 +++++++++
 tb/tb_alu_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the 74181 ALU sequencing controller.
package alu_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Logic-mode (M=1) function codes, S3..S0
    localparam logic [3:0] F_NOT_A  = 4'b0000;
    localparam logic [3:0] F_XOR    = 4'b0110;
    localparam logic [3:0] F_AND    = 4'b1011;
    localparam logic [3:0] F_PASS_A = 4'b1111;

endpackage

// File: rtl/alu_ctrl.sv
// Sequences one external 74181 ALU: latch operands, enable the ALU output for
// SETTLE cycles, capture the result and hold it until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | operands registered onto DR1/DR2, ALU output disabled
// EXEC  | ALU output enabled, settle down-counter running
// RESP  | captured result presented until res_ready
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_func,
    input  logic              cmd_m,
    input  logic              cmd_cn,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_chain,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              busy,
    output logic [3:0]        alu_s,
    output logic              alu_m,
    output logic              alu_cn,
    output logic [DATA_W-1:0] alu_dr1,
    output logic [DATA_W-1:0] alu_dr2,
    output logic              alu_b_n,
    input  logic [DATA_W-1:0] alu_q
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        settle_cnt;
    logic [DATA_W-1:0] last_res;
    logic              handshake;
    logic              exec_done;

    assign handshake = cmd_valid && cmd_ready;
    assign exec_done = (state == ST_EXEC) && (settle_cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (handshake) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_EXEC;
            ST_EXEC: if (exec_done) state_nxt = ST_RESP;
            ST_RESP: if (res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
            last_res   <= '0;
            alu_s      <= 4'd0;
            alu_m      <= 1'b0;
            alu_cn     <= 1'b0;
            alu_dr1    <= '0;
            alu_dr2    <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                alu_s   <= cmd_func;
                alu_m   <= cmd_m;
                alu_cn  <= cmd_cn;
                alu_dr1 <= cmd_chain ? last_res : cmd_a;
                alu_dr2 <= cmd_b;
            end
            if (state == ST_LOAD) begin
                settle_cnt <= SETTLE_INIT;
            end else if (state == ST_EXEC && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (exec_done) begin
                last_res <= alu_q;
            end
        end
    end

    // The captured result doubles as the chaining operand.
    assign res_data  = last_res;
    assign res_zero  = (res_data == '0);
    assign cmd_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign alu_b_n   = (state != ST_EXEC);

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a logic-mode 74181 model on each instance
// (SETTLE = 1 and SETTLE = 4 sharing the same command inputs).
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_func = 4'd0;
    logic       cmd_m = 1'b0;
    logic       cmd_cn = 1'b0;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic       cmd_chain = 1'b0;
    logic       res_ready = 1'b0;

    logic       cmd_ready1, res_valid1, res_zero1, busy1, alu_m1, alu_cn1, alu_b_n1;
    logic [7:0] res_data1, alu_dr1_1, alu_dr2_1, alu_q1;
    logic [3:0] alu_s1;
    logic       cmd_ready4, res_valid4, res_zero4, busy4, alu_m4, alu_cn4, alu_b_n4;
    logic [7:0] res_data4, alu_dr1_4, alu_dr2_4, alu_q4;
    logic [3:0] alu_s4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 74181 logic mode (M=1); arithmetic is not exercised. Disabled bus reads 0xFF.
    function automatic logic [7:0] alu181(input logic [3:0] s, input logic [7:0] a,
                                          input logic [7:0] b, input logic en_n);
        logic [7:0] f;
        case (s)
            4'h0: f = ~a;        4'h1: f = ~(a | b);  4'h2: f = ~a & b;    4'h3: f = 8'h00;
            4'h4: f = ~(a & b);  4'h5: f = ~b;        4'h6: f = a ^ b;     4'h7: f = a & ~b;
            4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);  4'hA: f = b;         4'hB: f = a & b;
            4'hC: f = 8'hFF;     4'hD: f = a | ~b;    4'hE: f = a | b;     default: f = a;
        endcase
        return en_n ? 8'hFF : f;
    endfunction

    assign alu_q1 = alu181(alu_s1, alu_dr1_1, alu_dr2_1, alu_b_n1);
    assign alu_q4 = alu181(alu_s4, alu_dr1_4, alu_dr2_4, alu_b_n4);

    alu_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_func(cmd_func), .cmd_m(cmd_m), .cmd_cn(cmd_cn), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_chain(cmd_chain), .res_valid(res_valid1), .res_ready(res_ready),
        .res_data(res_data1), .res_zero(res_zero1), .busy(busy1), .alu_s(alu_s1),
        .alu_m(alu_m1), .alu_cn(alu_cn1), .alu_dr1(alu_dr1_1), .alu_dr2(alu_dr2_1),
        .alu_b_n(alu_b_n1), .alu_q(alu_q1)
    );

    alu_ctrl #(.SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_func(cmd_func), .cmd_m(cmd_m), .cmd_cn(cmd_cn), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_chain(cmd_chain), .res_valid(res_valid4), .res_ready(res_ready),
        .res_data(res_data4), .res_zero(res_zero4), .busy(busy4), .alu_s(alu_s4),
        .alu_m(alu_m4), .alu_cn(alu_cn4), .alu_dr1(alu_dr1_4), .alu_dr2(alu_dr2_4),
        .alu_b_n(alu_b_n4), .alu_q(alu_q4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Runs one command on the selected instance; returns what was observed.
    // edges = edges after the handshake until res_valid (-1 on timeout).
    task automatic run_op(input logic [3:0] func, input logic [7:0] a, input logic [7:0] b,
                          input logic chain, input bit sel4,
                          output int lows, output int edges, output logic [7:0] data,
                          output logic zero, output logic [7:0] dr1_seen);
        int wait_cnt;
        cmd_func = func; cmd_m = 1'b1; cmd_cn = 1'b1;
        cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
        res_ready = 1'b0;
        wait_cnt = 0;
        while (!(sel4 ? cmd_ready4 : cmd_ready1) && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        tick();
        // scramble inputs so in-flight operation must not depend on them
        cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_func = ~func; cmd_chain = ~chain;
        cmd_m = 1'b0;
        dr1_seen = sel4 ? alu_dr1_4 : alu_dr1_1;
        lows = (sel4 ? alu_b_n4 : alu_b_n1) ? 0 : 1;
        edges = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!(sel4 ? alu_b_n4 : alu_b_n1)) lows++;
            if (sel4 ? res_valid4 : res_valid1) begin
                edges = i;
                break;
            end
        end
        data = sel4 ? res_data4 : res_data1;
        zero = sel4 ? res_zero4 : res_zero1;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (res_valid1 !== 1'b0 || busy1 !== 1'b0 || alu_b_n1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: res_valid=%b busy=%b alu_b_n=%b, want 0 0 1",
                     res_valid1, busy1, alu_b_n1);
        end
        checks++;
        if (res_data1 !== 8'h00 || alu_dr1_1 !== 8'h00 || alu_dr2_1 !== 8'h00 ||
            alu_s1 !== 4'h0 || alu_m1 !== 1'b0 || alu_cn1 !== 1'b0 || res_zero1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_regs: data=%h dr1=%h dr2=%h s=%h m=%b cn=%b zero=%b, want 00 00 00 0 0 0 1",
                     res_data1, alu_dr1_1, alu_dr2_1, alu_s1, alu_m1, alu_cn1, res_zero1);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready1 !== 1'b1 || cmd_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, want 1/1", cmd_ready1, cmd_ready4);
        end
    endtask

    task automatic test_xor;
        int lows, edges;
        logic [7:0] data, dr1;
        logic zero;
        do_reset();
        run_op(4'b0110, 8'h65, 8'hA7, 1'b0, 1'b0, lows, edges, data, zero, dr1);
        checks++;
        if (lows !== 1) begin
            errors++; $display("FAIL xor_enable_cycles: got %0d, want 1", lows);
        end
        checks++;
        if (edges !== 2) begin
            errors++; $display("FAIL xor_latency_edges: got %0d, want 2", edges);
        end
        checks++;
        if (data !== 8'hC2 || zero !== 1'b0) begin
            errors++; $display("FAIL xor_result: got %h zero=%b, want c2 zero=0", data, zero);
        end
        checks++;
        if (cmd_ready1 !== 1'b1 || res_valid1 !== 1'b0) begin
            errors++; $display("FAIL xor_return_idle: ready=%b valid=%b, want 1 0", cmd_ready1, res_valid1);
        end
    endtask

    task automatic test_chain;
        int lows, edges;
        logic [7:0] data, dr1;
        logic zero;
        do_reset();
        run_op(4'b1011, 8'h65, 8'hA7, 1'b0, 1'b0, lows, edges, data, zero, dr1);
        checks++;
        if (data !== 8'h25) begin
            errors++; $display("FAIL chain_and: got %h, want 25", data);
        end
        run_op(4'b0000, 8'h11, 8'h00, 1'b1, 1'b0, lows, edges, data, zero, dr1);
        checks++;
        if (dr1 !== 8'h25) begin
            errors++; $display("FAIL chain_dr1: got %h, want 25", dr1);
        end
        checks++;
        if (data !== 8'hDA) begin
            errors++; $display("FAIL chain_not: got %h, want da", data);
        end
    endtask

    task automatic test_zero;
        int lows, edges;
        logic [7:0] data, dr1;
        logic zero;
        run_op(4'b0110, 8'h65, 8'h65, 1'b0, 1'b0, lows, edges, data, zero, dr1);
        checks++;
        if (data !== 8'h00 || zero !== 1'b1) begin
            errors++; $display("FAIL zero_flag: got %h zero=%b, want 00 zero=1", data, zero);
        end
    endtask

    task automatic test_backpressure;
        int n;
        do_reset();
        cmd_func = 4'b0000; cmd_m = 1'b1; cmd_cn = 1'b1; cmd_a = 8'h65; cmd_b = 8'h00;
        cmd_chain = 1'b0; cmd_valid = 1'b1; res_ready = 1'b0;
        tick();
        // second command held pending throughout
        cmd_func = 4'b1111; cmd_a = 8'h33;
        n = 0;
        while (!res_valid1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!res_valid1) begin
            errors++; $display("FAIL bp_timeout: res_valid never rose");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid1 !== 1'b1 || res_data1 !== 8'h9A || cmd_ready1 !== 1'b0 || alu_dr1_1 !== 8'h65) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b dr1=%h, want 1 9a 0 65",
                         i, res_valid1, res_data1, cmd_ready1, alu_dr1_1);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (cmd_ready1 !== 1'b1 || res_valid1 !== 1'b0) begin
            errors++; $display("FAIL bp_release: ready=%b valid=%b, want 1 0", cmd_ready1, res_valid1);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || alu_dr1_1 !== 8'h33 || alu_s1 !== 4'hF) begin
            errors++; $display("FAIL bp_second_accept: busy=%b dr1=%h s=%h, want 1 33 f", busy1, alu_dr1_1, alu_s1);
        end
        tick();
        tick();
        checks++;
        if (res_valid1 !== 1'b1 || res_data1 !== 8'h33) begin
            errors++; $display("FAIL bp_second_result: valid=%b data=%h, want 1 33", res_valid1, res_data1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lows, edges;
        logic [7:0] data, dr1;
        logic zero;
        do_reset();
        run_op(4'b1111, 8'h5C, 8'h00, 1'b0, 1'b0, lows, edges, data, zero, dr1);
        cmd_func = 4'b0110; cmd_m = 1'b1; cmd_a = 8'h65; cmd_b = 8'hA7; cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (alu_b_n1 !== 1'b0) begin
            errors++; $display("FAIL mid_in_exec: alu_b_n=%b, want 0", alu_b_n1);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy1 !== 1'b0 || alu_b_n1 !== 1'b1 || res_valid1 !== 1'b0 || res_data1 !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: busy=%b b_n=%b valid=%b data=%h, want 0 1 0 00",
                     busy1, alu_b_n1, res_valid1, res_data1);
        end
        rst_n = 1'b1;
        run_op(4'b1111, 8'h77, 8'h00, 1'b1, 1'b0, lows, edges, data, zero, dr1);
        checks++;
        if (data !== 8'h00 || dr1 !== 8'h00) begin
            errors++; $display("FAIL mid_chain_after_reset: data=%h dr1=%h, want 00 00", data, dr1);
        end
    endtask

    task automatic test_settle4;
        int lows, edges;
        logic [7:0] data, dr1;
        logic zero;
        do_reset();
        run_op(4'b0110, 8'h65, 8'hA7, 1'b0, 1'b1, lows, edges, data, zero, dr1);
        checks++;
        if (lows !== 4) begin
            errors++; $display("FAIL s4_enable_cycles: got %0d, want 4", lows);
        end
        checks++;
        if (edges !== 5) begin
            errors++; $display("FAIL s4_latency_edges: got %0d, want 5", edges);
        end
        checks++;
        if (data !== 8'hC2 || zero !== 1'b0) begin
            errors++; $display("FAIL s4_result: got %h zero=%b, want c2 0", data, zero);
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_chain();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_settle4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
